// File: rtl/ext.sv
// Immediate extender: 16-bit immediate to 32 bits (zero/sign), with a registered copy and valid/sign flags.
// Optional LUI placement (upper-half) is enabled by defining EXT_LUI_EN.
module ext (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXTOp,
  input  logic [15:0] Imm16,
`ifdef EXT_LUI_EN
  input  logic        Lui,
`endif
  input  logic        en,
  output logic [31:0] ExtImm,
  output logic [31:0] ExtImm_q,
  output logic        valid_q,
  output logic        neg_q
);

  logic [31:0] ext_s;
  logic [31:0] ext_q_r;
  logic        valid_r;
  logic        neg_r;

  function automatic logic [31:0] extend16(input logic sign_ext, input logic [15:0] imm);
    logic [31:0] res;
    if (sign_ext) begin
      res = {{16{imm[15]}}, imm};
    end else begin
      res = {16'h0000, imm};
    end
    return res;
  endfunction

  // Combinational extension; LUI placement takes priority over EXTOp when built in
  always_comb begin
    ext_s = 32'h0000_0000;
`ifdef EXT_LUI_EN
    if (Lui) begin
      ext_s = {Imm16, 16'h0000};
    end else begin
      ext_s = extend16(EXTOp, Imm16);
    end
`else
    ext_s = extend16(EXTOp, Imm16);
`endif
  end

  assign ExtImm = ext_s;

  // Pipeline copy: reset beats enable; valid sticks until the next reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      ext_q_r <= 32'h0000_0000;
      valid_r <= 1'b0;
      neg_r   <= 1'b0;
    end else if (en) begin
      ext_q_r <= ext_s;
      valid_r <= 1'b1;
      neg_r   <= ext_s[31];
    end else begin
      ext_q_r <= ext_q_r;
      valid_r <= valid_r;
      neg_r   <= neg_r;
    end
  end

  assign ExtImm_q = ext_q_r;
  assign valid_q  = valid_r;
  assign neg_q    = neg_r;

endmodule

// File: tb/tb_ext.sv
// Self-checking bench for ext: combinational extension table plus a scoreboard for the registered stage.
// LUI cases are compiled in only when EXT_LUI_EN is defined.
module tb_ext;

  logic        clk;
  logic        reset;
  logic        EXTOp;
  logic [15:0] Imm16;
`ifdef EXT_LUI_EN
  logic        Lui;
`endif
  logic        en;
  logic [31:0] ExtImm;
  logic [31:0] ExtImm_q;
  logic        valid_q;
  logic        neg_q;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] imm;
    logic        neg;
    logic        valid;
  } exp_t;

  exp_t sb_q[$];

  ext dut (
    .clk      (clk),
    .reset    (reset),
    .EXTOp    (EXTOp),
    .Imm16    (Imm16),
`ifdef EXT_LUI_EN
    .Lui      (Lui),
`endif
    .en       (en),
    .ExtImm   (ExtImm),
    .ExtImm_q (ExtImm_q),
    .valid_q  (valid_q),
    .neg_q    (neg_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Drive a load at the falling edge and record what the stage must show afterwards
  task automatic drive_load(input logic op, input logic [15:0] imm, input logic [31:0] exp);
    EXTOp = op;
    Imm16 = imm;
    en    = 1'b1;
    sb_q.push_back('{imm: exp, neg: exp[31], valid: 1'b1});
  endtask

  // Pop one expectation and compare it against the registered outputs
  task automatic check_stage(input string tag);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({tag, "_q"},     ExtImm_q,        e.imm);
      check_eq({tag, "_neg"},   {31'd0, neg_q},   {31'd0, e.neg});
      check_eq({tag, "_valid"}, {31'd0, valid_q}, {31'd0, e.valid});
    end
  endtask

  logic        c_op  [6];
  logic [15:0] c_imm [6];
  logic [31:0] c_exp [6];

  initial begin
    c_op[0] = 1'b0; c_imm[0] = 16'hf000; c_exp[0] = 32'h0000_f000;
    c_op[1] = 1'b1; c_imm[1] = 16'h7000; c_exp[1] = 32'h0000_7000;
    c_op[2] = 1'b1; c_imm[2] = 16'hf000; c_exp[2] = 32'hffff_f000;
    c_op[3] = 1'b1; c_imm[3] = 16'h8000; c_exp[3] = 32'hffff_8000;
    c_op[4] = 1'b1; c_imm[4] = 16'h7fff; c_exp[4] = 32'h0000_7fff;
    c_op[5] = 1'b0; c_imm[5] = 16'hffff; c_exp[5] = 32'h0000_ffff;

    reset = 1'b0;
    en    = 1'b0;
    EXTOp = 1'b0;
    Imm16 = 16'h0000;
`ifdef EXT_LUI_EN
    Lui   = 1'b0;
`endif

    // Reset held for two edges
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q",     ExtImm_q,        32'h0000_0000);
    check_eq("rst_valid", {31'd0, valid_q}, 32'd0);
    check_eq("rst_neg",   {31'd0, neg_q},   32'd0);

    // Combinational table, run while still in reset: output must track inputs
    for (int i = 0; i < 6; i++) begin
      EXTOp = c_op[i];
      Imm16 = c_imm[i];
      #1;
      check_eq($sformatf("comb%0d", i), ExtImm, c_exp[i]);
    end
    EXTOp = 1'b0;
    Imm16 = 16'hf000;
    #100;
    check_eq("zext_hold100", ExtImm, 32'h0000_f000);

    // Release reset, then load a negative value
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("rel_valid", {31'd0, valid_q}, 32'd0);
    drive_load(1'b1, 16'hf000, 32'hffff_f000);
    @(negedge clk);
    check_stage("load_neg");

    // Enable low: changing input must not disturb the stage
    en    = 1'b0;
    Imm16 = 16'h1234;
    EXTOp = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("hold_q",     ExtImm_q,        32'hffff_f000);
    check_eq("hold_valid", {31'd0, valid_q}, 32'd1);
    check_eq("hold_neg",   {31'd0, neg_q},   32'd1);
    check_eq("hold_comb",  ExtImm,          32'h0000_1234);

    // Back-to-back loads across positive/negative/zero-extended values
    drive_load(1'b1, 16'h7fff, 32'h0000_7fff);
    @(negedge clk);
    check_stage("load_pos");
    drive_load(1'b0, 16'h8000, 32'h0000_8000);
    @(negedge clk);
    check_stage("load_zext");
    drive_load(1'b1, 16'h8000, 32'hffff_8000);
    @(negedge clk);
    check_stage("load_min");

    // Reset asserted together with enable clears the stage
    reset = 1'b0;
    en    = 1'b1;
    EXTOp = 1'b1;
    Imm16 = 16'hffff;
    @(negedge clk);
    check_eq("midrst_q",     ExtImm_q,        32'h0000_0000);
    check_eq("midrst_valid", {31'd0, valid_q}, 32'd0);
    check_eq("midrst_neg",   {31'd0, neg_q},   32'd0);
    check_eq("midrst_comb",  ExtImm,          32'hffff_ffff);

    // After release with enable low, nothing is loaded yet
    reset = 1'b1;
    en    = 1'b0;
    @(negedge clk);
    check_eq("post_rst_valid", {31'd0, valid_q}, 32'd0);
    drive_load(1'b1, 16'h0001, 32'h0000_0001);
    @(negedge clk);
    check_stage("first_after_rst");

`ifdef EXT_LUI_EN
    en    = 1'b0;
    Lui   = 1'b1;
    EXTOp = 1'b1;
    Imm16 = 16'h1234;
    #1;
    check_eq("lui_comb", ExtImm, 32'h1234_0000);
    @(negedge clk);
    drive_load(1'b1, 16'hf234, 32'hf234_0000);
    @(negedge clk);
    check_stage("lui_reg");
    en  = 1'b0;
    Lui = 1'b0;
    #1;
    check_eq("lui_off", ExtImm, 32'hffff_f234);
`endif

    en = 1'b0;
    check_eq("sb_drained", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
